// File: rtl/dpram_copy_engine.sv
// Dual-port RAM copy engine: streams len words from src to dst,
// reading on port A and writing on port B one cycle later.
module dpram_copy_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] mem_addr_a,
   output logic                  mem_read_en_a,
   input  logic [DATA_WIDTH-1:0] mem_read_data_a,
   output logic [ADDR_WIDTH-1:0] mem_addr_b,
   output logic                  mem_write_en_b,
   output logic [DATA_WIDTH-1:0] mem_write_data_b
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_rd_cnt;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH-1:0] r_addr_a;
   logic [ADDR_WIDTH-1:0] r_addr_b;
   logic                  r_rd_en;
   logic                  r_wr_en;
   logic                  r_busy;
   logic                  r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_len    <= '0;
         r_rd_cnt <= '0;
         r_count  <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_rd_en  <= 1'b0;
         r_wr_en  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         // Each read turns into a write one cycle later at the mirrored offset.
         r_wr_en <= r_rd_en;
         if (r_rd_en)
            r_addr_b <= r_dst + (r_addr_a - r_src);
         if (r_wr_en)
            r_count <= r_count + 1'b1;

         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_src    <= src_addr;
                  r_dst    <= dst_addr;
                  r_len    <= len;
                  r_count  <= '0;
                  r_addr_a <= src_addr;
                  if (len != '0) begin
                     r_rd_en  <= 1'b1;
                     r_rd_cnt <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                     r_busy   <= 1'b1;
                     r_state  <= S_RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end
               end
            end
            S_RUN: begin
               if (abort || (r_rd_cnt == r_len)) begin
                  r_rd_en <= 1'b0;
                  r_state <= S_DRAIN;
               end else begin
                  r_rd_en  <= 1'b1;
                  r_addr_a <= r_addr_a + 1'b1;
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_FIN;
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign count            = r_count;
   assign mem_addr_a       = r_addr_a;
   assign mem_read_en_a    = r_rd_en;
   assign mem_addr_b       = r_addr_b;
   assign mem_write_en_b   = r_wr_en;
   assign mem_write_data_b = r_wr_en ? mem_read_data_a : '0;

endmodule
